// File: rtl/mmio_pkg.sv
// Shared MMIO bus definitions: widths, arbiter state encoding, master IDs and
// the transaction record carried from a requester to the target-side registers.
package mmio_pkg;

    localparam int MMIO_AW = 30;
    localparam int MMIO_DW = 32;
    localparam int MMIO_MW = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic [MMIO_AW-1:0] addr;
        logic [MMIO_DW-1:0] data;
        logic [MMIO_MW-1:0] mask;
        logic               wren;
    } txn_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; on contention the
// holder of prio wins, and prio moves to the loser after every accepted grant.
module rr_arb2
    import mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    master_e prio_q, prio_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (prio_q == MST_M1) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = gnt[0] ? MST_M1 : MST_M0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= MST_M0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one MMIO target port between two masters: round-robin grant in IDLE,
// registered bus strobes, and a single outstanding read steered back to its owner.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               m0_req,
    input  logic [MMIO_AW-1:0] m0_addr,
    input  logic [MMIO_DW-1:0] m0_wdata,
    input  logic [MMIO_MW-1:0] m0_mask,
    input  logic               m0_wren,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [MMIO_DW-1:0] m0_rdata,

    input  logic               m1_req,
    input  logic [MMIO_AW-1:0] m1_addr,
    input  logic [MMIO_DW-1:0] m1_wdata,
    input  logic [MMIO_MW-1:0] m1_mask,
    input  logic               m1_wren,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [MMIO_DW-1:0] m1_rdata,

    output logic [MMIO_AW-1:0] o_mmio_addr,
    output logic [MMIO_DW-1:0] o_mmio_data,
    output logic [MMIO_MW-1:0] o_mmio_mask,
    output logic               o_mmio_wren,
    output logic               o_mmio_rden,
    input  logic [MMIO_DW-1:0] i_mmio_data
);

    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    master_e            owner_q, owner_d;

    logic [1:0]         arb_req, arb_gnt;
    logic               accept, read_done;
    master_e            sel;
    txn_t               m0_txn, m1_txn, txn;

    logic [MMIO_AW-1:0] addr_q;
    logic [MMIO_DW-1:0] data_q;
    logic [MMIO_MW-1:0] mask_q;
    logic               wren_q, rden_q;
    logic               m0_rvalid_q, m1_rvalid_q;
    logic [MMIO_DW-1:0] m0_rdata_q, m1_rdata_q;

    assign m0_txn = '{addr: m0_addr, data: m0_wdata, mask: m0_mask, wren: m0_wren};
    assign m1_txn = '{addr: m1_addr, data: m1_wdata, mask: m1_mask, wren: m1_wren};

    // Requests only reach the picker while no read is outstanding.
    always_comb begin
        arb_req = 2'b00;
        if (state_q == ST_IDLE) begin
            arb_req = {m1_req, m0_req};
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (accept),
        .gnt     (arb_gnt)
    );

    assign m0_gnt    = arb_gnt[0];
    assign m1_gnt    = arb_gnt[1];
    assign accept    = |arb_gnt;
    assign sel       = arb_gnt[1] ? MST_M1 : MST_M0;
    assign txn       = (sel == MST_M1) ? m1_txn : m0_txn;
    assign read_done = (state_q == ST_RD_WAIT) && (lat_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            owner_q   <= MST_M0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !txn.wren) begin
                    state_d   = ST_RD_WAIT;
                    lat_cnt_d = LAT_INIT;
                    owner_d   = sel;
                end
            end
            ST_RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: data registers are reset too, because their reset value is visible on the bus and on rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
            wren_q <= 1'b0;
            rden_q <= 1'b0;
        end else begin
            wren_q <= accept && txn.wren;
            rden_q <= accept && !txn.wren;
            if (accept) begin
                addr_q <= txn.addr;
                mask_q <= txn.mask;
                data_q <= txn.wren ? txn.data : '0;
            end
        end
    end

    // Read data is sampled in the last RD_WAIT cycle and presented one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= read_done && (owner_q == MST_M0);
            m1_rvalid_q <= read_done && (owner_q == MST_M1);
            if (read_done && (owner_q == MST_M0)) begin
                m0_rdata_q <= i_mmio_data;
            end
            if (read_done && (owner_q == MST_M1)) begin
                m1_rdata_q <= i_mmio_data;
            end
        end
    end

    assign o_mmio_addr = addr_q;
    assign o_mmio_data = data_q;
    assign o_mmio_mask = mask_q;
    assign o_mmio_wren = wren_q;
    assign o_mmio_rden = rden_q;
    assign m0_rvalid   = m0_rvalid_q;
    assign m1_rvalid   = m1_rvalid_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: a write/contention vector table, directed read
// sequences (READ_LAT 1 and 3), and a randomized run against a timestamp model.
module tb_mmio_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_wren, m1_wren;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, i_mmio_data;
    logic [3:0]  m0_mask, m1_mask;

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, o_wren, o_rden;
    logic [31:0] m0_rdata, m1_rdata, o_data;
    logic [29:0] o_addr;
    logic [3:0]  o_mask;

    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_wren, f_rden;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_data;
    logic [29:0] f_addr;
    logic [3:0]  f_mask;

    always #5 clk = ~clk;

    mmio_arbiter #(.READ_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_wren(m0_wren),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_wren(m1_wren),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .o_mmio_addr(o_addr), .o_mmio_data(o_data), .o_mmio_mask(o_mask),
        .o_mmio_wren(o_wren), .o_mmio_rden(o_rden), .i_mmio_data(i_mmio_data)
    );

    mmio_arbiter #(.READ_LAT(1)) u_fast (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_wren(m0_wren),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_wren(m1_wren),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .o_mmio_addr(f_addr), .o_mmio_data(f_data), .o_mmio_mask(f_mask),
        .o_mmio_wren(f_wren), .o_mmio_rden(f_rden), .i_mmio_data(i_mmio_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_wren = 0; m0_addr = '0; m0_wdata = '0; m0_mask = '0;
        m1_req = 0; m1_wren = 0; m1_addr = '0; m1_wdata = '0; m1_mask = '0;
    endtask

    // Leaves the bench at a falling edge with reset released: cycle 0.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic        r0, w0;
        logic [29:0] a0;
        logic [31:0] d0;
        logic [3:0]  k0;
        logic        r1, w1;
        logic [29:0] a1;
        logic [31:0] d1;
        logic [3:0]  k1;
        logic        eg0, eg1, ewr, erd;
        logic [29:0] ea;
        logic [31:0] ed;
        logic [3:0]  ek;
    } vec_t;

    localparam logic [29:0] A0 = 30'h20;
    localparam logic [31:0] D0 = 32'hA0A0_A0A0;
    localparam logic [3:0]  K0 = 4'hF;
    localparam logic [29:0] A1 = 30'h30;
    localparam logic [31:0] D1 = 32'hB1B1_B1B1;
    localparam logic [3:0]  K1 = 4'h3;

    vec_t tbl[11];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        rst = 1'b0;
        i_mmio_data = '0;
        idle_inputs();

        // Bus columns show the result of the previous row's grant.
        tbl[0]  = '{1,1,A0,D0,K0, 1,1,A1,D1,K1, 1,0, 0,0, 30'h0,  32'h0,         4'h0};
        tbl[1]  = '{1,1,A0,D0,K0, 1,1,A1,D1,K1, 0,1, 1,0, A0,     D0,            K0};
        tbl[2]  = '{1,1,A0,D0,K0, 1,1,A1,D1,K1, 1,0, 1,0, A1,     D1,            K1};
        tbl[3]  = '{1,1,A0,D0,K0, 1,1,A1,D1,K1, 0,1, 1,0, A0,     D0,            K0};
        tbl[4]  = '{1,1,A0,D0,K0, 1,1,A1,D1,K1, 1,0, 1,0, A1,     D1,            K1};
        tbl[5]  = '{1,1,A0,D0,K0, 1,1,A1,D1,K1, 0,1, 1,0, A0,     D0,            K0};
        tbl[6]  = '{0,0,A0,D0,K0, 0,0,A1,D1,K1, 0,0, 1,0, A1,     D1,            K1};
        tbl[7]  = '{1,1,30'h100,32'hDEAD_BEEF,4'hF, 0,0,A1,D1,K1, 1,0, 0,0, A1, D1, K1};
        tbl[8]  = '{0,0,A0,D0,K0, 1,1,30'h55,32'h0000_AB00,4'h2, 0,1, 1,0, 30'h100, 32'hDEAD_BEEF, 4'hF};
        tbl[9]  = '{0,0,A0,D0,K0, 0,0,A1,D1,K1, 0,0, 1,0, 30'h55,  32'h0000_AB00, 4'h2};
        tbl[10] = '{0,0,A0,D0,K0, 0,0,A1,D1,K1, 0,0, 0,0, 30'h55,  32'h0000_AB00, 4'h2};

        // ---------------- write / contention table ----------------
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            m0_req = tbl[i].r0; m0_wren = tbl[i].w0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0; m0_mask = tbl[i].k0;
            m1_req = tbl[i].r1; m1_wren = tbl[i].w1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1; m1_mask = tbl[i].k1;
            #1;
            check($sformatf("tbl%0d_m0_gnt", i), {31'b0, m0_gnt}, {31'b0, tbl[i].eg0});
            check($sformatf("tbl%0d_m1_gnt", i), {31'b0, m1_gnt}, {31'b0, tbl[i].eg1});
            check($sformatf("tbl%0d_wren", i),   {31'b0, o_wren}, {31'b0, tbl[i].ewr});
            check($sformatf("tbl%0d_rden", i),   {31'b0, o_rden}, {31'b0, tbl[i].erd});
            check($sformatf("tbl%0d_addr", i),   {2'b0, o_addr},  {2'b0, tbl[i].ea});
            check($sformatf("tbl%0d_data", i),   o_data,          tbl[i].ed);
            check($sformatf("tbl%0d_mask", i),   {28'b0, o_mask}, {28'b0, tbl[i].ek});
            @(negedge clk);
        end

        // ---------------- read, READ_LAT = 1 ----------------
        reset_dut();
        i_mmio_data = 32'h1234_5678;
        m1_req = 1; m1_wren = 0; m1_addr = 30'h10;
        #1;
        check("r1_n_m1_gnt", {31'b0, f_m1_gnt}, 32'd1);
        @(negedge clk);
        m1_req = 0;
        m0_req = 1; m0_wren = 1; m0_addr = 30'h77; m0_wdata = 32'h7777_0000; m0_mask = 4'hC;
        #1;
        check("r1_b_rden",   {31'b0, f_rden}, 32'd1);
        check("r1_b_addr",   {2'b0, f_addr},  32'h10);
        check("r1_b_data",   f_data,          32'h0);
        check("r1_b_wren",   {31'b0, f_wren}, 32'd0);
        check("r1_b_gnt",    {30'b0, f_m1_gnt, f_m0_gnt}, 32'd0);
        @(negedge clk);
        #1;
        check("r1_b1_rden",  {31'b0, f_rden}, 32'd0);
        check("r1_b1_gnt",   {30'b0, f_m1_gnt, f_m0_gnt}, 32'd0);
        check("r1_b1_rv",    {31'b0, f_m1_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        check("r1_b2_m1_rv",    {31'b0, f_m1_rvalid}, 32'd1);
        check("r1_b2_m1_rdata", f_m1_rdata, 32'h1234_5678);
        check("r1_b2_m0_rv",    {31'b0, f_m0_rvalid}, 32'd0);
        check("r1_b2_m0_gnt",   {31'b0, f_m0_gnt}, 32'd1);
        @(negedge clk);
        m0_req = 0;
        #1;
        check("r1_b3_m1_rv",    {31'b0, f_m1_rvalid}, 32'd0);
        check("r1_b3_rdata_hold", f_m1_rdata, 32'h1234_5678);
        check("r1_b3_wren",     {31'b0, f_wren}, 32'd1);
        check("r1_b3_addr",     {2'b0, f_addr}, 32'h77);

        // ---------------- read blocks waiting write, READ_LAT = 3 ----------------
        reset_dut();
        i_mmio_data = 32'hCAFE_F00D;
        m0_req = 1; m0_wren = 0; m0_addr = 30'h44;
        m1_req = 1; m1_wren = 1; m1_addr = 30'h66; m1_wdata = 32'h0000_600D; m1_mask = 4'hF;
        #1;
        check("rb_n_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("rb_n_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        @(negedge clk);
        m0_req = 0;
        #1;
        check("rb_b_rden",   {31'b0, o_rden}, 32'd1);
        check("rb_b_addr",   {2'b0, o_addr}, 32'h44);
        check("rb_b_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rb_b%0d_m1_gnt", k), {31'b0, m1_gnt}, 32'd0);
            check($sformatf("rb_b%0d_wren", k),   {31'b0, o_wren}, 32'd0);
            check($sformatf("rb_b%0d_m0_rv", k),  {31'b0, m0_rvalid}, 32'd0);
        end
        @(negedge clk);
        #1;
        check("rb_ret_m0_rv",    {31'b0, m0_rvalid}, 32'd1);
        check("rb_ret_m0_rdata", m0_rdata, 32'hCAFE_F00D);
        check("rb_ret_m1_gnt",   {31'b0, m1_gnt}, 32'd1);
        @(negedge clk);
        m1_req = 0;
        #1;
        check("rb_wr_wren",  {31'b0, o_wren}, 32'd1);
        check("rb_wr_addr",  {2'b0, o_addr}, 32'h66);
        check("rb_wr_data",  o_data, 32'h0000_600D);
        check("rb_wr_m0_rv", {31'b0, m0_rvalid}, 32'd0);

        // ---------------- reset during an outstanding read ----------------
        @(negedge clk);
        i_mmio_data = 32'hBADB_AD00;
        m0_req = 1; m0_wren = 0; m0_addr = 30'h88;
        #1;
        check("rr_n_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        @(negedge clk);
        m0_req = 0;
        #1;
        check("rr_b_rden", {31'b0, o_rden}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rr_rst_addr",  {2'b0, o_addr}, 32'h0);
        check("rr_rst_data",  o_data, 32'h0);
        check("rr_rst_mask",  {28'b0, o_mask}, 32'h0);
        check("rr_rst_strb",  {30'b0, o_wren, o_rden}, 32'h0);
        check("rr_rst_rv",    {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        check("rr_rst_rdata", m0_rdata | m1_rdata, 32'h0);
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rr_norv%0d", k), {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        end
        @(negedge clk);
        m0_req = 1; m0_wren = 1; m1_req = 1; m1_wren = 1;
        #1;
        check("rr_prio_gnt", {30'b0, m1_gnt, m0_gnt}, 32'b01);
        @(negedge clk);
        idle_inputs();

        // ---------------- randomized run against a timestamp model ----------------
        begin : random_phase
            int unsigned cyc, ready_cyc, rd_sample;
            bit          rd_pend, prio;
            int          rd_owner, k;
            bit          p_req[2], p_wren[2];
            logic [29:0] p_addr[2];
            logic [31:0] p_wdata[2];
            logic [3:0]  p_mask[2];
            logic [1:0]  eg;
            logic [29:0] e_addr;
            logic [31:0] e_data;
            logic [3:0]  e_mask;
            logic        e_wren, e_rden;
            logic [1:0]  e_rv;
            logic [31:0] e_rd[2];

            reset_dut();
            cyc = 0; ready_cyc = 0; rd_sample = 0; rd_pend = 0; prio = 0; rd_owner = 0;
            e_addr = '0; e_data = '0; e_mask = '0; e_wren = 0; e_rden = 0; e_rv = '0;
            e_rd[0] = '0; e_rd[1] = '0;
            for (int m = 0; m < 2; m++) begin
                p_req[m] = 0; p_wren[m] = 0; p_addr[m] = '0; p_wdata[m] = '0; p_mask[m] = '0;
            end

            for (int n = 0; n < 2000; n++) begin
                for (int m = 0; m < 2; m++) begin
                    if (!p_req[m] && $urandom_range(0, 99) < 60) begin
                        p_req[m]   = 1;
                        p_wren[m]  = 1'($urandom_range(0, 1));
                        p_addr[m]  = 30'($urandom);
                        p_wdata[m] = $urandom;
                        p_mask[m]  = 4'($urandom);
                    end
                end
                m0_req = p_req[0]; m0_wren = p_wren[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_mask = p_mask[0];
                m1_req = p_req[1]; m1_wren = p_wren[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_mask = p_mask[1];
                i_mmio_data = $urandom;
                #1;

                eg = 2'b00;
                if (cyc >= ready_cyc) begin
                    if (p_req[0] && p_req[1]) eg = prio ? 2'b10 : 2'b01;
                    else                      eg = {p_req[1], p_req[0]};
                end

                check("rnd_gnt",      {30'b0, m1_gnt, m0_gnt}, {30'b0, eg});
                check("rnd_strobes",  {30'b0, o_wren, o_rden}, {30'b0, e_wren, e_rden});
                check("rnd_addr",     {2'b0, o_addr}, {2'b0, e_addr});
                check("rnd_data",     o_data, e_data);
                check("rnd_mask",     {28'b0, o_mask}, {28'b0, e_mask});
                check("rnd_rvalid",   {30'b0, m1_rvalid, m0_rvalid}, {30'b0, e_rv});
                check("rnd_m0_rdata", m0_rdata, e_rd[0]);
                check("rnd_m1_rdata", m1_rdata, e_rd[1]);

                e_wren = 0; e_rden = 0; e_rv = '0;
                if (rd_pend && cyc == rd_sample) begin
                    e_rv[rd_owner]   = 1'b1;
                    e_rd[rd_owner]   = i_mmio_data;
                    rd_pend          = 0;
                end
                if (eg != 2'b00) begin
                    k      = eg[1] ? 1 : 0;
                    e_addr = p_addr[k];
                    e_mask = p_mask[k];
                    if (p_wren[k]) begin
                        e_data = p_wdata[k];
                        e_wren = 1;
                    end else begin
                        e_data    = '0;
                        e_rden    = 1;
                        rd_pend   = 1;
                        rd_owner  = k;
                        rd_sample = cyc + 1 + LAT;
                        ready_cyc = cyc + 2 + LAT;
                    end
                    prio     = (k == 0);
                    p_req[k] = 0;
                end

                @(negedge clk);
                cyc++;
            end
            idle_inputs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

- Shares the single CPU MMIO port between two requesters: the `cpu_top` core and a second bus master (debug loader / DMA).
- Round-robin arbitration, one transaction per grant.
- Registers the target-side bus and tracks one outstanding read until its data returns.
- Sits between the requesters and the MMIO decode / peripherals, using the same word-addressed, byte-masked MMIO format.

## Interface

Parameters:
- `READ_LAT`, default 1: cycles from `o_mmio_rden` to valid `i_mmio_data`. Legal range is 1..4.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `m0_req` / `m1_req`, in, 1 each: transaction request; held until granted.
- `m0_addr` / `m1_addr`, in, 30 each: word address (byte address >> 2).
- `m0_wdata` / `m1_wdata`, in, 32 each: write data.
- `m0_mask` / `m1_mask`, in, 4 each: byte-enable mask; bit i enables byte i.
- `m0_wren` / `m1_wren`, in, 1 each: 1 = write, 0 = read.
- `m0_gnt` / `m1_gnt`, out, 1 each: combinational accept; transaction taken at the clock edge where `req` and `gnt` are both high.
- `m0_rvalid` / `m1_rvalid`, out, 1 each: one-cycle read-data-valid pulse.
- `m0_rdata` / `m1_rdata`, out, 32 each: read data, valid while `rvalid` is high.
- `o_mmio_addr`, out, 30: target word address (registered).
- `o_mmio_data`, out, 32: target write data (registered).
- `o_mmio_mask`, out, 4: target byte mask (registered).
- `o_mmio_wren`, out, 1: one-cycle write strobe.
- `o_mmio_rden`, out, 1: one-cycle read strobe.
- `i_mmio_data`, in, 32: target read data.

## Operation

States:
- IDLE: grants possible.
- RD_WAIT: read outstanding; counter `lat_cnt` runs from `READ_LAT` down to 0.

Grant rule, evaluated only in IDLE:
- Only one requester asserting `req`: grant it.
- Both asserting `req`: grant the one selected by `prio`.
- `prio` flips to the non-granted master after every accepted transaction, read or write.
- In RD_WAIT both `gnt` outputs are 0.

Accepted write:
- Next cycle drives addr/data/mask with `o_mmio_wren`=1 for exactly one cycle.
- State stays IDLE, so writes can issue back-to-back every cycle.

Accepted read:
- Next cycle drives addr with `o_mmio_rden`=1 for one cycle, and `o_mmio_data`=0.
- Owner ID is latched; state enters RD_WAIT.

Read return:
- When `lat_cnt` expires, `i_mmio_data` is captured into the owner's `rdata`.
- The owner's `rvalid` pulses for one cycle; state returns to IDLE.

Signal holding rules:
- `o_mmio_addr`, `o_mmio_mask` and `o_mmio_data` hold their last values when no strobe is active.
- `mX_rdata` holds until the next read completes for that master.

Other rules:
- A read and a write never appear on the bus in the same cycle; `o_mmio_wren` and `o_mmio_rden` are never both 1.
- Requester protocol: once `req` is high, `addr`/`wdata`/`mask`/`wren` are stable until `gnt`. `req` may drop, or change to a new transaction, in the cycle after `gnt`.
- Reset values: all strobes, `gnt`, `rvalid` = 0; addr, data, mask, rdata = 0; state IDLE; `prio` = m0.
- Reset during RD_WAIT aborts the read: no `rvalid` ever issues for it.

## Timing

- Request accepted at the edge ending cycle N; the bus strobe is in cycle B = N+1.
- Write: `o_mmio_wren`=1 in cycle B only, and the requester may be granted again in cycle N+1.
- Read: `i_mmio_data` is valid in cycle B+`READ_LAT` and sampled at the end of that cycle.
- `rvalid` and `rdata` appear in cycle B+`READ_LAT`+1.
- The arbiter is IDLE again in that same cycle, so a new grant can coincide with `rvalid`.
- Read-to-read throughput is one read per `READ_LAT`+2 cycles.
- `gnt` is combinational from `req`, state and `prio`. Everything else is registered.

## Structure

- Shared `mmio_pkg` holds:
  - `MMIO_AW`=30, `MMIO_DW`=32, `MMIO_MW`=4;
  - the state encoding (IDLE, RD_WAIT);
  - master ID constants.
- One natural sub-module, `rr_arb2`: a 2-way round-robin picker holding `prio`, with inputs `req[1:0]`, `advance` and outputs `gnt[1:0]`.
- The rest (bus registers, latency counter, return steering) lives in `mmio_arbiter`.

## Test plan

1. **Single write:** m0 writes addr 0x0000_0100, data 0xDEADBEEF, mask 0b1111 → `m0_gnt` in cycle N; cycle N+1 shows `o_mmio_wren`=1 with those values; `o_mmio_rden`=0.
2. **Contention:** m0 and m1 both request writes continuously for 6 cycles after reset → grants alternate m0, m1, m0, … with one `o_mmio_wren` pulse per cycle.
3. **Read with READ_LAT=1:** m1 reads addr 0x10 while the target model returns 0x12345678 → `o_mmio_rden` in cycle B; `m1_rvalid`=1 with rdata 0x12345678 in cycle B+2. Both `gnt` outputs stay 0 in cycles B..B+1.
4. **Read blocks a waiting write:** m0 reads while m1 requests a write → m1's write strobe appears only in cycle B+`READ_LAT`+2. `m0_rvalid` and `m1_gnt` coincide.
5. **Reset mid-read:** `rst` is asserted in cycle B+1 of a READ_LAT=3 read → no `rvalid`, all outputs 0 the next cycle, `prio` back to m0.
6. **Partial-mask write:** m1 writes mask 0b0010 → `o_mmio_mask`=0b0010, exact one-cycle `o_mmio_wren`.
